// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER IOBUS timer block: register offsets,
// CTRL bit positions, timer FSM states and an address-match helper.
// Latency: n/a (package). Backpressure: n/a.
package otter_io_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [11:0] OFF_SW    = 12'h000;
  localparam logic [11:0] OFF_LED   = 12'h020;
  localparam logic [11:0] OFF_CTRL  = 12'h100;
  localparam logic [11:0] OFF_PRESC = 12'h104;
  localparam logic [11:0] OFF_LOAD  = 12'h108;
  localparam logic [11:0] OFF_COUNT = 12'h10C;
  localparam logic [11:0] OFF_STAT  = 12'h110;

  // CTRL register bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Exact full-address match against base + offset
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [11:0] off);
    return addr == (base + {20'd0, off});
  endfunction

endpackage

// File: rtl/otter_iobus_timer_if.sv
// Control/status link between the IOBUS register file and the timer core.
// Latency: wires only. Backpressure: none, start/stop are single-cycle pulses.
// Ports: ctrl side drives start/stop/auto_rl/presc/load, core side returns count/expire.
interface otter_iobus_timer_if;
  logic        start;    // EN written 0->1
  logic        stop;     // EN written 0
  logic        auto_rl;  // reload on expiry instead of stopping
  logic [15:0] presc;
  logic [31:0] load;
  logic [31:0] count;
  logic        expire;   // one-cycle pulse, same cycle as the expiring tick

  modport ctrl (output start, stop, auto_rl, presc, load,
                input  count, expire);
  modport core (input  start, stop, auto_rl, presc, load,
                output count, expire);
endinterface

// File: rtl/otter_timer_core.sv
// Prescaler plus 32-bit down-counter with IDLE/RUN/DONE sequencing.
// Latency: count loads on the start edge, first tick one cycle later when PRESC=0.
// Backpressure: none; expire is a combinational pulse decoded from state flops.
// Ports: clk, rst (async active-high), tif (core side of the timer link).
module otter_timer_core
  import otter_io_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  otter_iobus_timer_if.core tif
);

  timer_state_t state_q;
  logic [15:0]  pre_q;
  logic [31:0]  count_q;
  logic         tick;

  // >= keeps the prescaler from running to 0xFFFF if PRESC is lowered mid-run
  assign tick       = (state_q == RUN) && (pre_q >= tif.presc);
  assign tif.expire = tick && (count_q == 32'd0);
  assign tif.count  = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= 16'd0;
      count_q <= 32'd0;
    end else if (tif.stop) begin
      // count is deliberately held so software can read where it stopped
      state_q <= IDLE;
    end else if (tif.start) begin
      state_q <= RUN;
      count_q <= tif.load;
      pre_q   <= 16'd0;
    end else if (state_q == RUN) begin
      pre_q <= tick ? 16'd0 : pre_q + 16'd1;
      if (tick) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (tif.auto_rl) begin
          count_q <= tif.load;
        end else begin
          state_q <= DONE;
        end
      end
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// IOBUS responder: switch/LED registers plus a prescaled interval timer.
// Latency: writes land on the strobe edge; read data is registered, valid the next cycle.
// Backpressure: none, every bus cycle completes in one clock.
// Ports: CLK/RST, IOBUS_ADDR/OUT/WR in, IOBUS_IN out, SWITCHES in, LEDS out, INTR out.
module otter_iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          SW_W      = 16,
  parameter int          LED_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      IOBUS_IN,
  input  logic [SW_W-1:0]  SWITCHES,
  output logic [LED_W-1:0] LEDS,
  output logic             INTR
);

  logic [LED_W-1:0]  led_q,   led_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [15:0]       presc_q, presc_d;
  logic [31:0]       load_q,  load_d;
  logic              exp_q,   exp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic hit_sw, hit_led, hit_ctrl, hit_presc, hit_load, hit_count, hit_stat;
  logic wr_ctrl;

  otter_iobus_timer_if tmr_if ();

  otter_timer_core u_core (
    .clk (CLK),
    .rst (RST),
    .tif (tmr_if.core)
  );

  assign hit_sw    = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_SW);
  assign hit_led   = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_LED);
  assign hit_ctrl  = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_CTRL);
  assign hit_presc = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_PRESC);
  assign hit_load  = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_LOAD);
  assign hit_count = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_COUNT);
  assign hit_stat  = addr_hit(IOBUS_ADDR, BASE_ADDR, OFF_STAT);

  assign wr_ctrl = IOBUS_WR && hit_ctrl;

  // Start only on a rising EN; rewriting EN=1 (e.g. to flip IE) leaves the timer alone
  assign tmr_if.start   = wr_ctrl && IOBUS_OUT[CTRL_EN] && !ctrl_q[CTRL_EN];
  assign tmr_if.stop    = wr_ctrl && !IOBUS_OUT[CTRL_EN];
  assign tmr_if.auto_rl = ctrl_q[CTRL_AUTO];
  assign tmr_if.presc   = presc_q;
  assign tmr_if.load    = load_q;

  always_comb begin
    led_d   = led_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    load_d  = load_q;
    rdata_d = 32'd0;

    if (IOBUS_WR && hit_led)   led_d   = IOBUS_OUT[LED_W-1:0];
    if (wr_ctrl)               ctrl_d  = IOBUS_OUT[CTRL_W-1:0];
    if (IOBUS_WR && hit_presc) presc_d = IOBUS_OUT[15:0];
    if (IOBUS_WR && hit_load)  load_d  = IOBUS_OUT;

    // Expiry set is OR'd in after the clear so a coincident expiry wins
    exp_d = exp_q;
    if (IOBUS_WR && hit_stat && IOBUS_OUT[0]) exp_d = 1'b0;
    if (tmr_if.expire)                        exp_d = 1'b1;

    // Read mux uses pre-edge state, so a write cycle returns the old value
    if (hit_sw)    rdata_d[SW_W-1:0]   = sw_sync_q;
    if (hit_led)   rdata_d[LED_W-1:0]  = led_q;
    if (hit_ctrl)  rdata_d[CTRL_W-1:0] = ctrl_q;
    if (hit_presc) rdata_d[15:0]       = presc_q;
    if (hit_load)  rdata_d             = load_q;
    if (hit_count) rdata_d             = tmr_if.count;
    if (hit_stat)  rdata_d[0]          = exp_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q     <= '0;
      ctrl_q    <= '0;
      presc_q   <= '0;
      load_q    <= '0;
      exp_q     <= 1'b0;
      rdata_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      load_q    <= load_d;
      exp_q     <= exp_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign IOBUS_IN = rdata_q;
  assign LEDS     = led_q;
  assign INTR     = exp_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_otter_iobus_timer.sv
module tb_otter_iobus_timer;
  import otter_io_pkg::*;

  localparam logic [31:0] A_SW    = 32'h1100_0000;
  localparam logic [31:0] A_LED   = 32'h1100_0020;
  localparam logic [31:0] A_CTRL  = 32'h1100_0100;
  localparam logic [31:0] A_PRESC = 32'h1100_0104;
  localparam logic [31:0] A_LOAD  = 32'h1100_0108;
  localparam logic [31:0] A_COUNT = 32'h1100_010C;
  localparam logic [31:0] A_STAT  = 32'h1100_0110;
  localparam logic [31:0] A_HOLE  = 32'h1100_0004;
  localparam logic [31:0] A_FAR   = 32'h1100_1020;

  logic        CLK;
  logic        RST;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic        INTR;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;  // expected IOBUS_IN one edge after this cycle
  } vec_t;

  vec_t vecs [20];

  otter_iobus_timer dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .SWITCHES   (SWITCHES),
    .LEDS       (LEDS),
    .INTR       (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, return 1ns after the rising edge
  task automatic cyc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge CLK);
    IOBUS_WR   = wr;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = wdata;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] st();
    return {30'd0, dut.u_core.state_q};
  endfunction

  initial begin
    vecs[0]  = '{1'b1, A_LED,   32'h0000_A5A5, 32'h0000_0000};
    vecs[1]  = '{1'b0, A_LED,   32'h0000_0000, 32'h0000_A5A5};
    vecs[2]  = '{1'b0, A_SW,    32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b1, A_PRESC, 32'h1234_5678, 32'h0000_0000};
    vecs[4]  = '{1'b0, A_PRESC, 32'h0000_0000, 32'h0000_5678};
    vecs[5]  = '{1'b1, A_CTRL,  32'hFFFF_FFFE, 32'h0000_0000};
    vecs[6]  = '{1'b0, A_CTRL,  32'h0000_0000, 32'h0000_0006};
    vecs[7]  = '{1'b1, A_LOAD,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[8]  = '{1'b0, A_LOAD,  32'h0000_0000, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, A_COUNT, 32'h0000_0055, 32'h0000_0000};
    vecs[10] = '{1'b0, A_COUNT, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{1'b1, A_SW,    32'h0000_FFFF, 32'h0000_0000};
    vecs[12] = '{1'b0, A_SW,    32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{1'b1, A_HOLE,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{1'b0, A_HOLE,  32'h0000_0000, 32'h0000_0000};
    vecs[15] = '{1'b0, A_STAT,  32'h0000_0000, 32'h0000_0000};
    vecs[16] = '{1'b1, A_CTRL,  32'h0000_0000, 32'h0000_0006};
    vecs[17] = '{1'b0, A_CTRL,  32'h0000_0000, 32'h0000_0000};
    vecs[18] = '{1'b1, A_FAR,   32'h0000_FFFF, 32'h0000_0000};
    vecs[19] = '{1'b0, A_LED,   32'h0000_0000, 32'h0000_A5A5};

    RST        = 1'b1;
    IOBUS_ADDR = 32'd0;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;
    SWITCHES   = 16'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_iobus_in", IOBUS_IN, 32'd0);
    check("rst_leds", {16'd0, LEDS}, 32'd0);
    check("rst_intr", {31'd0, INTR}, 32'd0);
    check("rst_state", st(), {30'd0, IDLE});
    @(negedge CLK);
    RST = 1'b0;

    // Register file vectors
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), IOBUS_IN, vecs[i].rdata);
      if (i == 0) check("leds_after_wr", {16'd0, LEDS}, 32'h0000_A5A5);
    end
    check("idle_no_start", st(), {30'd0, IDLE});

    // Switch synchronizer: visible on the third edge after the change
    @(negedge CLK);
    SWITCHES   = 16'h1234;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = A_SW;
    @(posedge CLK);
    #1;
    check("sw_edge1", IOBUS_IN, 32'd0);
    cyc(1'b0, A_SW, 32'd0);
    check("sw_edge2", IOBUS_IN, 32'd0);
    cyc(1'b0, A_SW, 32'd0);
    check("sw_edge3", IOBUS_IN, 32'h0000_1234);

    // One-shot: PRESC=0 LOAD=3 CTRL=EN|IE -> expires on 4th tick
    cyc(1'b1, A_PRESC, 32'd0);
    cyc(1'b1, A_LOAD, 32'd3);
    cyc(1'b1, A_CTRL, 32'h5);
    check("os_state_run", st(), {30'd0, RUN});
    cyc(1'b0, A_COUNT, 32'd0);
    check("os_count_loaded", IOBUS_IN, 32'd3);
    cyc(1'b0, A_COUNT, 32'd0);
    cyc(1'b0, A_COUNT, 32'd0);
    check("os_intr_tick3", {31'd0, INTR}, 32'd0);
    cyc(1'b0, A_COUNT, 32'd0);
    check("os_intr_tick4", {31'd0, INTR}, 32'd1);
    check("os_state_done", st(), {30'd0, DONE});
    cyc(1'b0, A_COUNT, 32'd0);
    check("os_count_zero", IOBUS_IN, 32'd0);
    cyc(1'b0, A_STAT, 32'd0);
    check("os_stat_exp", IOBUS_IN, 32'd1);
    repeat (3) cyc(1'b0, A_COUNT, 32'd0);
    check("os_done_hold", IOBUS_IN, 32'd0);

    // LOAD=0 expires on the first tick after start
    cyc(1'b1, A_CTRL, 32'h0);
    check("stop_idle", st(), {30'd0, IDLE});
    cyc(1'b1, A_STAT, 32'h1);
    cyc(1'b1, A_LOAD, 32'd0);
    cyc(1'b1, A_CTRL, 32'h5);
    check("l0_intr_start", {31'd0, INTR}, 32'd0);
    cyc(1'b0, A_COUNT, 32'd0);
    check("l0_intr_tick1", {31'd0, INTR}, 32'd1);

    // Auto-reload: PRESC=1 LOAD=2 -> expiry every 6 cycles
    cyc(1'b1, A_CTRL, 32'h0);
    cyc(1'b1, A_STAT, 32'h1);
    cyc(1'b1, A_PRESC, 32'd1);
    cyc(1'b1, A_LOAD, 32'd2);
    cyc(1'b1, A_CTRL, 32'h7);
    repeat (5) cyc(1'b0, A_COUNT, 32'd0);
    check("ar_intr_s5", {31'd0, INTR}, 32'd0);
    cyc(1'b0, A_COUNT, 32'd0);
    check("ar_intr_s6", {31'd0, INTR}, 32'd1);
    check("ar_state_run", st(), {30'd0, RUN});
    cyc(1'b1, A_STAT, 32'h1);
    check("ar_clr_s7", {31'd0, INTR}, 32'd0);
    repeat (4) cyc(1'b0, A_COUNT, 32'd0);
    check("ar_intr_s11", {31'd0, INTR}, 32'd0);
    cyc(1'b0, A_COUNT, 32'd0);
    check("ar_intr_s12", {31'd0, INTR}, 32'd1);
    cyc(1'b1, A_STAT, 32'h1);
    check("ar_clr_s13", {31'd0, INTR}, 32'd0);
    repeat (4) cyc(1'b0, A_COUNT, 32'd0);
    check("ar_intr_s17", {31'd0, INTR}, 32'd0);
    cyc(1'b1, A_STAT, 32'h1);
    check("ar_set_wins_s18", {31'd0, INTR}, 32'd1);
    cyc(1'b0, A_STAT, 32'd0);
    check("ar_stat_after", IOBUS_IN, 32'd1);

    // Reset mid-run with COUNT=0x10 (long prescale keeps it there)
    cyc(1'b1, A_CTRL, 32'h6);
    cyc(1'b1, A_PRESC, 32'h0000_FFFF);
    cyc(1'b1, A_LOAD, 32'h10);
    cyc(1'b1, A_CTRL, 32'h7);
    cyc(1'b0, A_COUNT, 32'd0);
    check("mr_count_pre", IOBUS_IN, 32'h10);
    check("mr_intr_pre", {31'd0, INTR}, 32'd1);
    check("mr_leds_pre", {16'd0, LEDS}, 32'h0000_A5A5);
    #1;
    RST = 1'b1;
    #1;
    check("mr_count_async", dut.u_core.count_q, 32'd0);
    check("mr_intr_async", {31'd0, INTR}, 32'd0);
    check("mr_leds_async", {16'd0, LEDS}, 32'd0);
    check("mr_iobus_async", IOBUS_IN, 32'd0);
    check("mr_state_async", st(), {30'd0, IDLE});
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) cyc(1'b0, A_COUNT, 32'd0);
    check("mr_count_after", IOBUS_IN, 32'd0);
    check("mr_state_after", st(), {30'd0, IDLE});
    cyc(1'b0, A_CTRL, 32'd0);
    check("mr_ctrl_after", IOBUS_IN, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
